div_sqrt_sequencer: RTL
=======================

# div_sqrt_sequencer

Sequencer for the shared iterative fraction datapath used by divide and square-root. It accepts one operation at a time and steers the datapath through load, iterate and normalize phases. It drives the fraction-MSB select that feeds the result selecter, then holds the finished result until the writeback stage accepts it. It sits between the issue stage (start handshake) and the result selecter/writeback (result handshake).

## Interface
Parameters:
- DIV_ITERATIONS, 26, ITERATE cycles for divide; legal 1..31.
- SQRT_ITERATIONS, 25, ITERATE cycles for square root; legal 1..31.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; accepted only when ready=1.
- op_sqrt  in  1  sampled with start: 0 = divide, 1 = square root.
- special_case  in  1  sampled with start: operands are NaN/Inf/zero and need no iteration.
- special_msb_select  in  fraction_msb::fraction_msb_select  sampled with start: MSB source for the special result.
- flush  in  1  synchronous abort; forces IDLE.
- result_ready  in  1  writeback can take the result.
- ready  out  1  high only in IDLE.
- load  out  1  one-cycle pulse that loads operands into the iterative datapath.
- iter_enable  out  1  datapath performs one iteration this cycle.
- iter_count  out  5  iterations remaining, including the current one.
- fraction_msb_select  out  fraction_msb::fraction_msb_select  MSB source for the result selecter.
- result_valid  out  1  result available; held until accepted.

## Operation
- States: IDLE, LOAD, ITERATE, NORMALIZE, SPECIAL, DONE. Encoding is free.
- IDLE: ready=1.
  - start=1 and special_case=0: latch op_sqrt and go to LOAD.
  - start=1 and special_case=1: latch special_msb_select and go to SPECIAL.
  - start while ready=0 is ignored and not queued.
- LOAD: load=1 for one cycle.
  - Set iter_count to DIV_ITERATIONS, or SQRT_ITERATIONS when op_sqrt was latched.
  - Go to ITERATE.
- ITERATE: iter_enable=1.
  - iter_count decrements each cycle.
  - When iter_count=1 on a clock edge, iter_count becomes 0 and the state goes to NORMALIZE.
- NORMALIZE: one cycle; iter_enable=0. Go to DONE.
- SPECIAL: one cycle. Go to DONE.
- DONE: result_valid=1.
  - result_valid=1 and result_ready=1 on an edge completes the transfer; go to IDLE.
  - Otherwise stay in DONE, with every output stable.
- fraction_msb_select:
  - ZERO in IDLE, LOAD and ITERATE.
  - RESULT in NORMALIZE and in DONE after a normal operation.
  - The latched special_msb_select in SPECIAL and in DONE after a special operation.
- flush=1 forces IDLE on the next edge from any state.
  - flush wins over start, over the iteration end, and over the result handshake.
  - A result_valid&result_ready on the same edge as flush still counts as delivered.
  - Latched op and select are don't-care after flush.
- Reset mid-operation: immediately returns to IDLE with reset values; nothing is retained.

## Timing
- Reset values:
  - ready=1.
  - load=0, iter_enable=0, result_valid=0.
  - iter_count=0.
  - fraction_msb_select=ZERO.
  - State IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Normal latency, with start sampled at edge 0:
  - LOAD in cycle 1.
  - ITERATE in cycles 2..N+1.
  - NORMALIZE in cycle N+2.
  - result_valid first high in cycle N+3.
  - Divide at default (N=26): result_valid at cycle 29. Square root (N=25): cycle 28.
- Special latency: SPECIAL in cycle 1; result_valid at cycle 2.
- Minimum issue interval:
  - result accepted on the first DONE cycle gives IDLE the next cycle.
  - Next start is therefore accepted N+4 cycles after the previous one for normal ops, 3 cycles for special ops.
- iter_count is valid only during ITERATE and reads 0 in all other states.

## Test plan
- Reset, then divide: reset_n low for 3 cycles, release, pulse start with op_sqrt=0 and special_case=0, result_ready=1.
  - Expect load at cycle 1.
  - Expect iter_enable for 26 cycles with iter_count 26..1.
  - Expect fraction_msb_select=RESULT from cycle 28.
  - Expect result_valid at cycle 29 for exactly one cycle, then ready=1 at cycle 30.
- Square root with backpressure: op_sqrt=1, result_ready=0 until cycle 35.
  - Expect result_valid high from cycle 28 through 35.
  - Expect outputs stable throughout and IDLE at cycle 36.
- Special case: start with special_case=1 and special_msb_select=ONE.
  - Expect no load or iter_enable.
  - Expect fraction_msb_select=ONE at cycles 1–2 and result_valid at cycle 2.
- Flush during ITERATE: flush at cycle 10 of a divide, with start asserted the same cycle.
  - Expect IDLE and ready=1 at cycle 11.
  - Expect iter_enable=0 and the start ignored.
- Start while busy: extra start pulses during ITERATE.
  - Expect no effect: same iteration count, a single result_valid.
- Asynchronous reset mid-DONE: drop reset_n between edges while result_valid=1.
  - Expect result_valid=0, ready=1 and iter_count=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/div_sqrt_sequencer.sv
// Control sequencer for the shared divide/square-root fraction datapath.
// Latency: N+3 cycles from start to result_valid (N iterations), 2 cycles for special operands.
// Backpressure: holds DONE with stable outputs until result_ready; start is only taken in IDLE.
package fraction_msb;
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        ONE    = 2'd1,
        RESULT = 2'd2
    } fraction_msb_select;
endpackage

module div_sqrt_sequencer #(
    parameter int DIV_ITERATIONS  = 26,
    parameter int SQRT_ITERATIONS = 25
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            op_sqrt,
    input  logic                            special_case,
    input  fraction_msb::fraction_msb_select special_msb_select,
    input  logic                            flush,
    input  logic                            result_ready,
    output logic                            ready,
    output logic                            load,
    output logic                            iter_enable,
    output logic [4:0]                      iter_count,
    output fraction_msb::fraction_msb_select fraction_msb_select,
    output logic                            result_valid
);

    localparam logic [4:0] DIV_N  = 5'(DIV_ITERATIONS);
    localparam logic [4:0] SQRT_N = 5'(SQRT_ITERATIONS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITERATE,
        NORMALIZE,
        SPECIAL,
        DONE
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [4:0]                      cnt;
    logic                            op_sqrt_q;
    logic                            special_q;
    fraction_msb::fraction_msb_select sel_q;
    logic                            accept;

    assign accept = (state == IDLE) && start && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            op_sqrt_q <= 1'b0;
            special_q <= 1'b0;
            sel_q     <= fraction_msb::ZERO;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_sqrt_q <= op_sqrt;
                special_q <= special_case;
                sel_q     <= special_msb_select;
            end
            // Counter is zero outside ITERATE so iter_count can be driven straight from it.
            if (flush) begin
                cnt <= 5'd0;
            end else begin
                case (state)
                    LOAD:    cnt <= op_sqrt_q ? SQRT_N : DIV_N;
                    ITERATE: cnt <= cnt - 5'd1;
                    default: cnt <= 5'd0;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        ready               = 1'b0;
        load                = 1'b0;
        iter_enable         = 1'b0;
        result_valid        = 1'b0;
        fraction_msb_select = fraction_msb::ZERO;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = special_case ? SPECIAL : LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = ITERATE;
            end
            ITERATE: begin
                iter_enable = 1'b1;
                if (cnt == 5'd1) begin
                    state_nxt = NORMALIZE;
                end
            end
            NORMALIZE: begin
                fraction_msb_select = fraction_msb::RESULT;
                state_nxt           = DONE;
            end
            SPECIAL: begin
                fraction_msb_select = sel_q;
                state_nxt           = DONE;
            end
            DONE: begin
                result_valid        = 1'b1;
                fraction_msb_select = special_q ? sel_q : fraction_msb::RESULT;
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    assign iter_count = cnt;

endmodule
